// File: rtl/btn_event_sched_pkg.sv
// Shared defaults and helpers for the button event scheduler.
package btn_event_sched_pkg;

    localparam int DEF_TICK_BITS    = 19;
    localparam int DEF_STABLE_TICKS = 3;
    localparam int STAB_CNT_W       = 3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_sched_if.sv
// Press-event valid/ready channel between the scheduler and its consumer.
interface btn_event_sched_if #(
    parameter int N_CH = 4
) ();
    import btn_event_sched_pkg::*;

    localparam int ID_W = id_width(N_CH);

    logic            ev_valid;
    logic [ID_W-1:0] ev_id;
    logic            ev_ready;

    modport master (output ev_valid, output ev_id, input ev_ready);
    modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/btn_event_sched_db_chan.sv
// One switch channel: 2-flop synchronizer, tick-based stability counter,
// debounced level and a combinational rise strobe aligned with the db update.
module db_chan
    import btn_event_sched_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    input  logic i_tick,
    output logic o_db,
    output logic o_rise
);

    logic                  r_meta;
    logic                  r_sync;
    logic                  r_db;
    logic [STAB_CNT_W-1:0] r_cnt;
    logic                  w_term;

    // Final qualifying tick: db takes the synchronized level on this edge.
    assign w_term = i_tick && (r_sync != r_db) &&
                    (r_cnt == STAB_CNT_W'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (w_term) begin
                    r_db  <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = w_term & r_sync;

endmodule

// File: rtl/btn_event_sched.sv
// Debounces N_CH switches and presents press events one at a time,
// round-robin across channels, on a valid/ready output register.
module btn_event_sched
    import btn_event_sched_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_BITS    = DEF_TICK_BITS,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   sw,
    output logic [N_CH-1:0]   db,
    output logic [N_CH-1:0]   ovf,
    input  logic              clr_ovf,
    btn_event_sched_if.master ev
);

    localparam int ID_W = id_width(N_CH);

    logic [TICK_BITS-1:0] r_presc;
    logic                 w_tick;
    logic [N_CH-1:0]      w_rise;
    logic [N_CH-1:0]      r_pend;
    logic [N_CH-1:0]      r_ovf;
    logic [N_CH-1:0]      w_grant;
    logic [N_CH-1:0]      w_ovf_set;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_id;
    logic                 r_valid;
    logic                 w_load;
    logic                 w_found;
    logic [ID_W-1:0]      w_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_presc <= '0;
        else        r_presc <= r_presc + 1'b1;
    end

    assign w_tick = (r_presc == '0);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        db_chan #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk    (clk),
            .rst_n  (reset),
            .i_sw   (sw[g]),
            .i_tick (w_tick),
            .o_db   (db[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_load = !r_valid || ev.ev_ready;

    // Search starts just after the last granted channel and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!w_found && r_pend[(int'(r_last) + k) % N_CH]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_last) + k) % N_CH);
            end
        end
    end

    assign w_grant   = (w_load && w_found) ? (N_CH'(1) << w_win) : '0;
    // A rise on a channel whose pending press is being granted this cycle is not a loss.
    assign w_ovf_set = w_rise & r_pend & ~w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_rise;
            r_ovf  <= (r_ovf & ~{N_CH{clr_ovf}}) | w_ovf_set;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_last  <= ID_W'(N_CH - 1);
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_id   <= w_win;
                r_last <= w_win;
            end
        end
    end

    assign ev.ev_valid = r_valid;
    assign ev.ev_id    = r_id;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed self-checking bench for btn_event_sched (N_CH=4, TICK_BITS=4, STABLE_TICKS=3).
module tb_btn_event_sched;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] db;
    logic [3:0] ovf;
    logic       clr_ovf;
    int         checks;
    int         failures;

    btn_event_sched_if #(.N_CH(4)) ev_if ();

    btn_event_sched #(
        .N_CH         (4),
        .TICK_BITS    (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .db      (db),
        .ovf     (ovf),
        .clr_ovf (clr_ovf),
        .ev      (ev_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_db(input int ch, input logic lvl, input int budget,
                           output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (db[ch] === lvl) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (ev_if.ev_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sw = 4'h0; ev_if.ev_ready = 1'b0; clr_ovf = 1'b0;
        reset = 1'b0;
        tick_n(3);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        sw = 4'h0; ev_if.ev_ready = 1'b0; clr_ovf = 1'b0;
        reset = 1'b0;
        tick_n(2);
        checks++; if (db !== 4'h0) begin failures++; $display("FAIL reset_db got=%h exp=0", db); end
        checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", ovf); end
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ev_if.ev_valid); end
        checks++; if (ev_if.ev_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", ev_if.ev_id); end
        reset = 1'b1;
    endtask

    task automatic test_press();
        int cyc;
        bit ok;
        do_reset();
        sw[0] = 1'b1;
        wait_db(0, 1'b1, 60, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL press_db_timeout got=0 exp=1"); end
        checks++; if (cyc < 35 || cyc > 50) begin failures++; $display("FAIL press_latency got=%0d exp=35..50", cyc); end
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL press_early_valid got=%b exp=0", ev_if.ev_valid); end
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b1) begin failures++; $display("FAIL press_valid got=%b exp=1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_id !== 2'd0) begin failures++; $display("FAIL press_id got=%0d exp=0", ev_if.ev_id); end
        tick_n(3);
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'd0) begin failures++; $display("FAIL press_hold got=%b/%0d exp=1/0", ev_if.ev_valid, ev_if.ev_id); end
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL press_consumed got=%b exp=0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_bounce();
        bit seen_valid;
        bit seen_db;
        do_reset();
        seen_valid = 1'b0;
        seen_db    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 0) sw[1] = ~sw[1];
            @(negedge clk);
            if (ev_if.ev_valid === 1'b1) seen_valid = 1'b1;
            if (db[1] !== 1'b0) seen_db = 1'b1;
        end
        sw[1] = 1'b0;
        checks++; if (seen_db) begin failures++; $display("FAIL bounce_db got=1 exp=0"); end
        checks++; if (seen_valid) begin failures++; $display("FAIL bounce_event got=1 exp=0"); end
        checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL bounce_ovf got=%h exp=0", ovf); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        ev_if.ev_ready = 1'b1;
        sw = 4'hF;
        wait_valid(80, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
        checks++; if (db !== 4'hF) begin failures++; $display("FAIL b2b_db got=%h exp=f", db); end
        checks++; if (ev_if.ev_id !== 2'd0) begin failures++; $display("FAIL b2b_id0 got=%0d exp=0", ev_if.ev_id); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'(k)) begin
                failures++;
                $display("FAIL b2b_seq got=%b/%0d exp=1/%0d", ev_if.ev_valid, ev_if.ev_id, k);
            end
        end
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", ev_if.ev_valid); end
        checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL b2b_ovf got=%h exp=0", ovf); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int cyc;
        bit ok;
        do_reset();
        sw[2] = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok || ev_if.ev_id !== 2'd2) begin failures++; $display("FAIL ovf_first got=%b/%0d exp=1/2", ok, ev_if.ev_id); end
        // second press: lands in pend while the output holds the first
        sw[2] = 1'b0;
        wait_db(2, 1'b0, 80, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_fall1 got=0 exp=1"); end
        sw[2] = 1'b1;
        wait_db(2, 1'b1, 80, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_rise1 got=0 exp=1"); end
        checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL ovf_pend_only got=%h exp=0", ovf); end
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'd2) begin failures++; $display("FAIL ovf_hold1 got=%b/%0d exp=1/2", ev_if.ev_valid, ev_if.ev_id); end
        // third press: pend already occupied, so it is lost
        sw[2] = 1'b0;
        wait_db(2, 1'b0, 80, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_fall2 got=0 exp=1"); end
        sw[2] = 1'b1;
        wait_db(2, 1'b1, 80, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_rise2 got=0 exp=1"); end
        checks++; if (ovf !== 4'b0100) begin failures++; $display("FAIL ovf_set got=%h exp=4", ovf); end
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'd2) begin failures++; $display("FAIL ovf_hold2 got=%b/%0d exp=1/2", ev_if.ev_valid, ev_if.ev_id); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (ovf !== 4'h0) begin failures++; $display("FAIL ovf_clear got=%h exp=0", ovf); end
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'd2) begin failures++; $display("FAIL ovf_pend_event got=%b/%0d exp=1/2", ev_if.ev_valid, ev_if.ev_id); end
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain got=%b exp=0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        sw = 4'b0010;
        tick_n(20);
        checks++; if (db !== 4'h0) begin failures++; $display("FAIL mid_pre_db got=%h exp=0", db); end
        reset = 1'b0;
        #1;
        checks++; if (db !== 4'h0 || ev_if.ev_valid !== 1'b0 || ovf !== 4'h0) begin failures++; $display("FAIL mid_qual_reset got=%h/%b/%h exp=0/0/0", db, ev_if.ev_valid, ovf); end
        tick_n(2);
        reset = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok || ev_if.ev_id !== 2'd1) begin failures++; $display("FAIL mid_requal got=%b/%0d exp=1/1", ok, ev_if.ev_id); end
        reset = 1'b0;
        #1;
        checks++; if (ev_if.ev_valid !== 1'b0 || ev_if.ev_id !== 2'd0 || db !== 4'h0) begin failures++; $display("FAIL mid_valid_reset got=%b/%0d/%h exp=0/0/0", ev_if.ev_valid, ev_if.ev_id, db); end
        sw = 4'b1010;
        tick_n(2);
        reset = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok || ev_if.ev_id !== 2'd1) begin failures++; $display("FAIL mid_first_grant got=%b/%0d exp=1/1", ok, ev_if.ev_id); end
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_id !== 2'd3) begin failures++; $display("FAIL mid_second_grant got=%b/%0d exp=1/3", ev_if.ev_valid, ev_if.ev_id); end
        @(negedge clk);
        checks++; if (ev_if.ev_valid !== 1'b0) begin failures++; $display("FAIL mid_drain got=%b exp=0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        sw             = 4'h0;
        clr_ovf        = 1'b0;
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
